bus_responder_8088: RTL

BUS_RESPONDER_8088 -- requirements
Module: bus_responder_8088

---
 rtl/bus_responder_8088.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_responder_8088.sv
// 8088 byte-wide bus slave: decodes a window of DEPTH bytes, answers reads and writes.
// Optional macro WAIT_STATE_EN stretches each read/write by WAIT_CYCLES clocks.
module bus_responder_8088 #(
    parameter logic [19:0] BASE_ADDR   = 20'h00400,
    parameter int          DEPTH       = 16,
    parameter bit          IS_IO       = 1'b0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] a,
    input  logic        ale,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        iom,
    inout  wire  [7:0]  ad,
    output logic        ready,
    output logic        bus_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [20:0] LIMIT = {1'b0, BASE_ADDR} + 21'(DEPTH);

    typedef enum logic [1:0] {IDLE, LATCHED, READ, WRITE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               written_q, written_d;
    logic               bus_err_q, bus_err_d;
    logic [7:0]         mem_q [DEPTH];
    logic               mem_we;

    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic               drive_c;

`ifdef WAIT_STATE_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    logic [3:0] wait_q, wait_d;

    assign ready = !(((state_q == READ) || (state_q == WRITE)) && (wait_q != 4'd0));
`else
    assign ready = 1'b1;
`endif

    assign hit_c = (iom == IS_IO)
                && ({1'b0, a} >= {1'b0, BASE_ADDR})
                && ({1'b0, a} < LIMIT);
    assign idx_c = IDX_W'(a - BASE_ADDR);

    // Drive only for a clean read strobe; ale or a second strobe releases the bus at once.
    assign drive_c = (state_q == READ) && !rd_n && wr_n && !ale && ready;
    assign ad      = drive_c ? rdata_q : 8'bzzzzzzzz;
    assign bus_err = bus_err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        written_d = written_q;
        bus_err_d = 1'b0;
        mem_we    = 1'b0;
`ifdef WAIT_STATE_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (ale && hit_c) begin
                    state_d = LATCHED;
                    idx_d   = idx_c;
                end
            end
            LATCHED: begin
                if (ale) begin
                    state_d = hit_c ? LATCHED : IDLE;
                    if (hit_c) idx_d = idx_c;
                end else if (!rd_n && !wr_n) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (!rd_n) begin
                    state_d = READ;
                    rdata_d = mem_q[idx_q];
                end else if (!wr_n) begin
                    state_d   = WRITE;
                    written_d = 1'b0;
                end
            end
            READ, WRITE: begin
                if (ale) begin
                    bus_err_d = 1'b1;
                    state_d   = hit_c ? LATCHED : IDLE;
                    if (hit_c) idx_d = idx_c;
                end else if (!rd_n && !wr_n) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else if ((state_q == READ) ? rd_n : wr_n) begin
                    state_d = IDLE;
                end else if ((state_q == WRITE) && ready && !written_q) begin
                    mem_we    = 1'b1;
                    written_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef WAIT_STATE_EN
        if ((state_d == READ) || (state_d == WRITE)) begin
            if (state_q == LATCHED) begin
                wait_d = WAIT_LOAD;
            end else if (wait_q != 4'd0) begin
                wait_d = wait_q - 4'd1;
            end
        end else begin
            wait_d = 4'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rdata_q   <= '0;
            written_q <= 1'b0;
            bus_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef WAIT_STATE_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            written_q <= written_d;
            bus_err_q <= bus_err_d;
            if (mem_we) mem_q[idx_q] <= ad;
`ifdef WAIT_STATE_EN
            wait_q    <= wait_d;
`endif
        end
    end

endmodule
